branch_resolve_unit: RTL and testbench

- Parametrised, registered branch resolution stage for the pipelined OTTER core.
- Takes RS1/RS2 operands, funct3, PC, B-immediate and a predicted-taken bit; evaluates all six RV32 branch conditions.
- Produces taken, branch target, redirect PC and mispredict flag through a one-deep output register with valid/ready handshake.
- Keeps saturating branch and mispredict counters for performance monitoring; sits between EX operand forwarding and the fetch redirect logic.

---
 rtl/branch_resolve_unit.sv | 145 ++++++++++++++
 tb/tb_branch_resolve_unit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// branch_resolve_unit
// Registered RV32 branch resolution stage with valid/ready output register
// and saturating branch / mispredict statistics counters.
// Revision: 1.0
// ============================================================================
module branch_resolve_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             FLUSH,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [XLEN-1:0]  RS1,
  input  logic [XLEN-1:0]  RS2,
  input  logic [2:0]       FUNCT3,
  input  logic [XLEN-1:0]  PC,
  input  logic [XLEN-1:0]  IMM,
  input  logic             PRED_TAKEN,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic             TAKEN,
  output logic [XLEN-1:0]  TARGET,
  output logic [XLEN-1:0]  REDIRECT_PC,
  output logic             MISPREDICT,
  output logic             ILLEGAL,
  output logic [CNT_W-1:0] BR_COUNT,
  output logic [CNT_W-1:0] MISP_COUNT,
  input  logic             CLR_STATS
);

  localparam logic [2:0]       c_f3_beq  = 3'b000;
  localparam logic [2:0]       c_f3_bne  = 3'b001;
  localparam logic [2:0]       c_f3_blt  = 3'b100;
  localparam logic [2:0]       c_f3_bge  = 3'b101;
  localparam logic [2:0]       c_f3_bltu = 3'b110;
  localparam logic [2:0]       c_f3_bgeu = 3'b111;
  localparam logic [XLEN-1:0]  c_four    = {{(XLEN-3){1'b0}}, 3'b100};
  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

  logic             w_eq;
  logic             w_lt;
  logic             w_ltu;
  logic             w_taken;
  logic             w_illegal;
  logic             w_misp;
  logic             w_accept;
  logic [XLEN-1:0]  w_target;
  logic [XLEN-1:0]  w_pc_plus4;
  logic [XLEN-1:0]  w_redirect;
  logic [CNT_W-1:0] w_br_next;
  logic [CNT_W-1:0] w_misp_next;

  logic             r_out_valid;
  logic             r_taken;
  logic [XLEN-1:0]  r_target;
  logic [XLEN-1:0]  r_redirect;
  logic             r_misp;
  logic             r_illegal;
  logic [CNT_W-1:0] r_br_count;
  logic [CNT_W-1:0] r_misp_count;

  always_comb begin
    w_eq      = (RS1 == RS2);
    w_lt      = ($signed(RS1) < $signed(RS2));
    w_ltu     = (RS1 < RS2);
    w_taken   = 1'b0;
    w_illegal = 1'b0;
    case (FUNCT3)
      c_f3_beq:  w_taken = w_eq;
      c_f3_bne:  w_taken = !w_eq;
      c_f3_blt:  w_taken = w_lt;
      c_f3_bge:  w_taken = !w_lt;
      c_f3_bltu: w_taken = w_ltu;
      c_f3_bgeu: w_taken = !w_ltu;
      default:   w_illegal = 1'b1;
    endcase

    // Both adders wrap silently at XLEN bits.
    w_target   = PC + IMM;
    w_pc_plus4 = PC + c_four;
    w_redirect = w_taken ? w_target : w_pc_plus4;
    w_misp     = !w_illegal && (w_taken != PRED_TAKEN);

    IN_READY = !FLUSH && (!r_out_valid || OUT_READY);
    w_accept = IN_VALID && IN_READY;

    // Clear takes effect first so a same-cycle accept lands on zero.
    w_br_next   = CLR_STATS ? '0 : r_br_count;
    w_misp_next = CLR_STATS ? '0 : r_misp_count;
    if (w_accept && !w_illegal && (w_br_next != c_cnt_max)) begin
      w_br_next = w_br_next + c_cnt_one;
    end
    if (w_accept && w_misp && (w_misp_next != c_cnt_max)) begin
      w_misp_next = w_misp_next + c_cnt_one;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_out_valid <= 1'b0;
      r_taken     <= 1'b0;
      r_target    <= '0;
      r_redirect  <= '0;
      r_misp      <= 1'b0;
      r_illegal   <= 1'b0;
    end else if (FLUSH) begin
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_taken     <= w_taken;
      r_target    <= w_target;
      r_redirect  <= w_redirect;
      r_misp      <= w_misp;
      r_illegal   <= w_illegal;
    end else if (OUT_READY) begin
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_br_count   <= '0;
      r_misp_count <= '0;
    end else begin
      r_br_count   <= w_br_next;
      r_misp_count <= w_misp_next;
    end
  end

  assign OUT_VALID   = r_out_valid;
  assign TAKEN       = r_taken;
  assign TARGET      = r_target;
  assign REDIRECT_PC = r_redirect;
  assign MISPREDICT  = r_misp;
  assign ILLEGAL     = r_illegal;
  assign BR_COUNT    = r_br_count;
  assign MISP_COUNT  = r_misp_count;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// tb_branch_resolve_unit
// Scoreboard bench: directed scenarios plus randomized traffic for
// branch_resolve_unit, checked against an arithmetic reference model.
// Revision: 1.0
// ============================================================================
module tb_branch_resolve_unit;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             CLK = 1'b0;
  logic             RST, FLUSH, IN_VALID, IN_READY;
  logic [XLEN-1:0]  RS1, RS2, PC, IMM;
  logic [2:0]       FUNCT3;
  logic             PRED_TAKEN, OUT_VALID, OUT_READY;
  logic             TAKEN, MISPREDICT, ILLEGAL, CLR_STATS;
  logic [XLEN-1:0]  TARGET, REDIRECT_PC;
  logic [CNT_W-1:0] BR_COUNT, MISP_COUNT;

  branch_resolve_unit #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .RS1(RS1), .RS2(RS2), .FUNCT3(FUNCT3), .PC(PC), .IMM(IMM),
    .PRED_TAKEN(PRED_TAKEN), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .TAKEN(TAKEN), .TARGET(TARGET), .REDIRECT_PC(REDIRECT_PC),
    .MISPREDICT(MISPREDICT), .ILLEGAL(ILLEGAL), .BR_COUNT(BR_COUNT),
    .MISP_COUNT(MISP_COUNT), .CLR_STATS(CLR_STATS)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        taken;
    logic [31:0] target;
    logic [31:0] redirect;
    logic        misp;
    logic        ill;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_on = 0;
  bit   m_valid = 0;
  int   m_br = 0;
  int   m_misp = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: conditions from plain integer arithmetic on 64-bit values.
  function automatic exp_t ref_model(logic [31:0] a, logic [31:0] b, logic [2:0] f,
                                     logic [31:0] pc, logic [31:0] imm, logic pred);
    exp_t   e;
    longint ua, ub, sa, sb, lp, li;
    bit     t, ill;
    ua = a; ub = b; lp = pc; li = imm;
    sa = a[31] ? ua - 64'd4294967296 : ua;
    sb = b[31] ? ub - 64'd4294967296 : ub;
    ill = 0;
    case (f)
      3'd0: t = (ua == ub);
      3'd1: t = (ua != ub);
      3'd4: t = (sa < sb);
      3'd5: t = !(sa < sb);
      3'd6: t = (ua < ub);
      3'd7: t = !(ua < ub);
      default: begin t = 0; ill = 1; end
    endcase
    e.taken    = t;
    e.ill      = ill;
    e.target   = 32'((lp + li) % 64'd4294967296);
    e.redirect = t ? e.target : 32'((lp + 4) % 64'd4294967296);
    e.misp     = !ill && (t != pred);
    return e;
  endfunction

  // Model: decides acceptance from its own view of the output register.
  initial begin
    bit   acc;
    exp_t e;
    forever begin
      @(posedge CLK);
      acc = IN_VALID && !FLUSH && (!m_valid || OUT_READY);
      if (RST) begin
        q.delete();
        m_valid = 0; m_br = 0; m_misp = 0;
      end else begin
        if (CLR_STATS) begin m_br = 0; m_misp = 0; end
        if (FLUSH) m_valid = 0;
        else if (acc) begin
          e = ref_model(RS1, RS2, FUNCT3, PC, IMM, PRED_TAKEN);
          q.push_back(e);
          m_valid = 1;
          if (!e.ill && m_br < CMAX) m_br++;
          if (e.misp && m_misp < CMAX) m_misp++;
        end else if (OUT_READY) m_valid = 0;
      end
    end
  end

  // Monitor: compares presented results and pops when consumed or flushed.
  initial begin
    forever begin
      @(negedge CLK);
      if (mon_on && !RST) begin
        chk("out_valid", OUT_VALID, m_valid);
        chk("in_ready", IN_READY, !FLUSH && (!m_valid || OUT_READY));
        chk("br_count", BR_COUNT, m_br);
        chk("misp_count", MISP_COUNT, m_misp);
        if (OUT_VALID === 1'b1) begin
          if (q.size() == 0) begin
            chk("unexpected_output", 1, 0);
          end else begin
            chk("taken", TAKEN, q[0].taken);
            chk("target", TARGET, q[0].target);
            chk("redirect_pc", REDIRECT_PC, q[0].redirect);
            chk("mispredict", MISPREDICT, q[0].misp);
            chk("illegal", ILLEGAL, q[0].ill);
            if (OUT_READY || FLUSH) void'(q.pop_front());
          end
        end
      end
    end
  end

  task automatic step(bit v, logic [31:0] a, logic [31:0] b, logic [2:0] f,
                      logic [31:0] pc, logic [31:0] imm, bit pred, bit ordy,
                      bit fl = 0, bit clr = 0);
    IN_VALID = v; RS1 = a; RS2 = b; FUNCT3 = f; PC = pc; IMM = imm;
    PRED_TAKEN = pred; OUT_READY = ordy; FLUSH = fl; CLR_STATS = clr;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int          br0;
    logic [31:0] a, b;
    RST = 1; FLUSH = 0; IN_VALID = 0; RS1 = 0; RS2 = 0; FUNCT3 = 0;
    PC = 0; IMM = 0; PRED_TAKEN = 0; OUT_READY = 0; CLR_STATS = 0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_out_valid", OUT_VALID, 0);
    chk("rst_taken", TAKEN, 0);
    chk("rst_target", TARGET, 0);
    chk("rst_redirect", REDIRECT_PC, 0);
    chk("rst_misp", MISPREDICT, 0);
    chk("rst_illegal", ILLEGAL, 0);
    chk("rst_br", BR_COUNT, 0);
    chk("rst_mispc", MISP_COUNT, 0);
    RST = 0;
    mon_on = 1;

    step(1, 5, 5, 3'b000, 32'h100, 32'h20, 0, 1);
    chk("beq_valid", OUT_VALID, 1);
    chk("beq_taken", TAKEN, 1);
    chk("beq_target", TARGET, 32'h120);
    chk("beq_redirect", REDIRECT_PC, 32'h120);
    chk("beq_misp", MISPREDICT, 1);
    chk("beq_br", BR_COUNT, 1);
    chk("beq_mispc", MISP_COUNT, 1);

    step(1, 32'hFFFF_FFFF, 1, 3'b100, 32'h200, 32'h40, 1, 1);
    chk("blt_neg_taken", TAKEN, 1);
    step(1, 32'hFFFF_FFFF, 1, 3'b110, 32'h200, 32'h40, 0, 1);
    chk("bltu_taken", TAKEN, 0);
    chk("bltu_redirect", REDIRECT_PC, 32'h204);
    step(1, 32'hFFFF_FFFF, 1, 3'b111, 32'h200, 32'h40, 1, 1);
    chk("bgeu_taken", TAKEN, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1);

    // Backpressure: hold bundle A while B waits.
    step(1, 1, 2, 3'b000, 32'h300, 32'h10, 0, 0);
    br0 = BR_COUNT;
    for (int i = 0; i < 3; i++) begin
      step(1, 7, 7, 3'b001, 32'h400, 32'h80, 0, 0);
      chk("bp_in_ready", IN_READY, 0);
      chk("bp_target_hold", TARGET, 32'h310);
      chk("bp_br_hold", BR_COUNT, br0);
    end
    step(1, 7, 7, 3'b001, 32'h400, 32'h80, 0, 1);
    chk("b2b_valid", OUT_VALID, 1);
    chk("b2b_target", TARGET, 32'h480);
    chk("b2b_redirect", REDIRECT_PC, 32'h404);
    chk("b2b_br", BR_COUNT, br0 + 1);

    // Flush a stalled result with a new bundle offered.
    step(1, 1, 1, 3'b000, 32'h600, 32'h4, 0, 0);
    br0 = BR_COUNT;
    step(1, 1, 1, 3'b000, 32'h600, 32'h4, 0, 0, 1);
    chk("flush_valid", OUT_VALID, 0);
    chk("flush_br", BR_COUNT, br0);

    step(1, 3, 3, 3'b010, 32'h500, 32'h8, 1, 1);
    chk("ill_illegal", ILLEGAL, 1);
    chk("ill_taken", TAKEN, 0);
    chk("ill_misp", MISPREDICT, 0);
    chk("ill_br", BR_COUNT, br0);
    step(1, 1, 2, 3'b000, 32'hFFFF_FFFC, 32'h8, 0, 1);
    chk("wrap_target", TARGET, 32'h4);

    // Saturation, then clear combined with an accept.
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    chk("clr_br", BR_COUNT, 0);
    for (int i = 0; i < 17; i++) step(1, 9, 9, 3'b000, 32'h700, 32'h10, 0, 1);
    chk("sat_br", BR_COUNT, 15);
    chk("sat_mispc", MISP_COUNT, 15);
    step(1, 9, 9, 3'b000, 32'h700, 32'h10, 1, 1, 0, 1);
    chk("clracc_br", BR_COUNT, 1);
    chk("clracc_mispc", MISP_COUNT, 0);

    for (int i = 0; i < 400; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = a;
        1: b = $urandom;
        2: b = {~a[31], a[30:0]};
        default: b = a + 32'($urandom_range(0, 2)) - 1;
      endcase
      if (i == 200) RST = 1;
      step($urandom_range(0, 9) < 7, a, b, 3'($urandom_range(0, 7)), $urandom,
           (i % 8 == 0) ? 32'hFFFF_FFF0 : $urandom, 1'($urandom_range(0, 1)),
           $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0,
           $urandom_range(0, 29) == 0);
      RST = 0;
    end
    repeat (3) step(0, 0, 0, 0, 0, 0, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
